vend_controller: RTL

- Transaction sequencer for the vending machine. Accumulates debounced coin pulses into a credit register and serves the item selection against a per-item price table.
- Runs a request/acknowledge handshake with the dispenser mechanism, then pays out the remaining credit as paced one-unit change pulses.
- Sits between the input debouncers and both the seven-segment display driver and the dispenser. credit drives the display directly.

---
 rtl/vend_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/vend_controller.sv
// vend_controller: vending transaction sequencer (coins, selection, dispense, change).
// Ports: clock/reset (async low), coin2/coin1/coin0 pulses, sel_valid/sel_item,
//   cancel, vend_ack in; credit, vend_req, vend_item, change_pulse,
//   coin_reject, short_credit, vend_fault, busy out.
module vend_controller #(
    parameter int PRICE0       = 5,
    parameter int PRICE1       = 7,
    parameter int PRICE2       = 10,
    parameter int PRICE3       = 12,
    parameter int MAX_CREDIT   = 9999,
    parameter int CHANGE_GAP   = 4,
    parameter int VEND_TIMEOUT = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        coin2,
    input  logic        coin1,
    input  logic        coin0,
    input  logic        sel_valid,
    input  logic [1:0]  sel_item,
    input  logic        cancel,
    input  logic        vend_ack,
    output logic [13:0] credit,
    output logic        vend_req,
    output logic [1:0]  vend_item,
    output logic        change_pulse,
    output logic        coin_reject,
    output logic        short_credit,
    output logic        vend_fault,
    output logic        busy
);

    localparam int TW = $clog2(VEND_TIMEOUT) + 1;
    localparam int GW = $clog2(CHANGE_GAP) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        DISPENSE,
        CHANGE
    } state_t;

    state_t        state, state_n;
    logic [13:0]   credit_n;
    logic [TW-1:0] timer, timer_n;
    logic [GW-1:0] gap, gap_n;
    logic [1:0]    item_n;
    logic          reject_n, short_n, fault_n;

    logic [2:0]    coin_sum;
    logic          any_coin;
    logic [14:0]   coin_total;
    logic          fits;
    logic [14:0]   acc;
    logic [14:0]   price;
    logic [14:0]   remain;
    logic [14:0]   refund;

    function automatic logic [14:0] price_of(input logic [1:0] idx);
        logic [14:0] p;
        unique case (idx)
            2'd0: p = 15'(PRICE0);
            2'd1: p = 15'(PRICE1);
            2'd2: p = 15'(PRICE2);
            2'd3: p = 15'(PRICE3);
        endcase
        return p;
    endfunction

    // Coin arithmetic is done at 15 bits so the ceiling compare cannot wrap.
    always_comb begin
        coin_sum   = (coin2 ? 3'd1 : 3'd0)
                   + (coin1 ? 3'd2 : 3'd0)
                   + (coin0 ? 3'd3 : 3'd0);
        any_coin   = coin2 | coin1 | coin0;
        coin_total = {1'b0, credit} + {12'd0, coin_sum};
        fits       = coin_total <= 15'(MAX_CREDIT);
        acc        = fits ? coin_total : {1'b0, credit};
        price      = price_of(sel_item);
        remain     = acc - price;
        refund     = {1'b0, credit} + price_of(vend_item);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            credit       <= '0;
            timer        <= '0;
            gap          <= '0;
            vend_item    <= '0;
            coin_reject  <= 1'b0;
            short_credit <= 1'b0;
            vend_fault   <= 1'b0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            timer        <= timer_n;
            gap          <= gap_n;
            vend_item    <= item_n;
            coin_reject  <= reject_n;
            short_credit <= short_n;
            vend_fault   <= fault_n;
        end
    end

    always_comb begin
        state_n  = state;
        credit_n = credit;
        timer_n  = timer;
        gap_n    = gap;
        item_n   = vend_item;
        reject_n = 1'b0;
        short_n  = 1'b0;
        fault_n  = 1'b0;

        unique case (state)
            IDLE, CREDIT: begin
                reject_n = any_coin && !fits;
                credit_n = 14'(acc);
                if (state == CREDIT && cancel) begin
                    // Same-cycle coins are already folded into acc.
                    gap_n   = '0;
                    state_n = CHANGE;
                end else if (state == CREDIT && sel_valid && acc >= price) begin
                    credit_n = 14'(remain);
                    item_n   = sel_item;
                    timer_n  = '0;
                    state_n  = DISPENSE;
                end else begin
                    short_n = sel_valid;
                    if (acc != 15'd0) begin
                        state_n = CREDIT;
                    end
                end
            end
            DISPENSE: begin
                reject_n = any_coin;
                if (vend_ack) begin
                    gap_n   = '0;
                    state_n = (credit != 14'd0) ? CHANGE : IDLE;
                end else if (timer == TW'(VEND_TIMEOUT - 1)) begin
                    // Dispenser never answered: give the price back.
                    fault_n  = 1'b1;
                    credit_n = 14'(refund);
                    gap_n    = '0;
                    state_n  = CHANGE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            CHANGE: begin
                reject_n = any_coin;
                if (gap == '0) begin
                    if (credit != 14'd0) begin
                        credit_n = credit - 14'd1;
                    end
                    if (credit <= 14'd1) begin
                        gap_n   = '0;
                        state_n = IDLE;
                    end else begin
                        gap_n = GW'(1);
                    end
                end else if (gap == GW'(CHANGE_GAP - 1)) begin
                    gap_n = '0;
                end else begin
                    gap_n = gap + 1'b1;
                end
            end
        endcase
    end

    // A change pulse is emitted on every cycle the gap counter sits at zero.
    assign change_pulse = (state == CHANGE) && (gap == '0);
    assign vend_req     = (state == DISPENSE);
    assign busy         = (state == DISPENSE) || (state == CHANGE);

endmodule
